// File: rtl/square_loc_gen.sv
// Random placement engine for the on-screen target square.
// Draws LFSR candidates, rejects off-screen or player-overlapping ones,
// and returns the accepted top-left corner with a one-cycle valid pulse.
module square_loc_gen #(
  parameter int unsigned        SCREEN_W   = 640,
  parameter int unsigned        SCREEN_H   = 480,
  parameter int unsigned        SQ_SIZE    = 20,
  parameter int unsigned        COORD_W    = 11,
  parameter int unsigned        LFSR_W     = 16,
  parameter logic [LFSR_W-1:0]  SEED       = LFSR_W'(16'hACE1),
  parameter int unsigned        MAX_TRIES  = 16,
  parameter int unsigned        FALLBACK_X = 0,
  parameter int unsigned        FALLBACK_Y = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               avoid_en,
  input  logic [COORD_W-1:0] avoid_x,
  input  logic [COORD_W-1:0] avoid_y,
  output logic [COORD_W-1:0] x_loc,
  output logic [COORD_W-1:0] y_loc,
  output logic               valid,
  output logic               busy,
  output logic               fallback
);

  localparam int unsigned XMAX = SCREEN_W - SQ_SIZE;
  localparam int unsigned YMAX = SCREEN_H - SQ_SIZE;
  localparam int unsigned XB   = $clog2(XMAX + 1);
  localparam int unsigned YB   = $clog2(YMAX + 1);
  localparam int unsigned CW1  = COORD_W + 1;
  localparam int unsigned TW   = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;

  // Maximal-length Galois (right-shift) feedback masks by width
  function automatic logic [LFSR_W-1:0] taps_for(input int unsigned w);
    case (w)
      3:       return LFSR_W'(32'h0000_0006);
      4:       return LFSR_W'(32'h0000_000C);
      5:       return LFSR_W'(32'h0000_0014);
      6:       return LFSR_W'(32'h0000_0030);
      7:       return LFSR_W'(32'h0000_0060);
      8:       return LFSR_W'(32'h0000_00B8);
      9:       return LFSR_W'(32'h0000_0110);
      10:      return LFSR_W'(32'h0000_0240);
      11:      return LFSR_W'(32'h0000_0500);
      12:      return LFSR_W'(32'h0000_0E08);
      13:      return LFSR_W'(32'h0000_1C80);
      14:      return LFSR_W'(32'h0000_3802);
      15:      return LFSR_W'(32'h0000_6000);
      17:      return LFSR_W'(32'h0001_2000);
      18:      return LFSR_W'(32'h0002_0400);
      19:      return LFSR_W'(32'h0007_2000);
      20:      return LFSR_W'(32'h0009_0000);
      21:      return LFSR_W'(32'h0014_0000);
      22:      return LFSR_W'(32'h0030_0000);
      23:      return LFSR_W'(32'h0042_0000);
      24:      return LFSR_W'(32'h00E1_0000);
      default: return LFSR_W'(32'h0000_B400);
    endcase
  endfunction

  localparam logic [LFSR_W-1:0] TAPS     = taps_for(LFSR_W);
  // A zero seed would lock the LFSR, so it is promoted to 1
  localparam logic [LFSR_W-1:0] SEED_EFF = (SEED == '0) ? LFSR_W'(1) : SEED;

  typedef enum logic [1:0] {IDLE, DRAW, CHECK} state_t;

  state_t             state, state_d;
  logic [LFSR_W-1:0]  lfsr, lfsr_d;
  logic [TW-1:0]      tries, tries_d;
  logic [COORD_W-1:0] cand_x, cand_y, cand_x_d, cand_y_d;
  logic [COORD_W-1:0] x_loc_d, y_loc_d;
  logic               valid_d, busy_d, fallback_d;
  logic [CW1-1:0]     cx, cy, ax, ay, dx, dy;
  logic               accept;

  // Free-running Galois step; never reaches zero from a nonzero state
  assign lfsr_d = (lfsr >> 1) ^ (lfsr[0] ? TAPS : '0);

  // Candidate acceptance: on-screen and clear of the exclusion square
  assign cx     = CW1'(cand_x);
  assign cy     = CW1'(cand_y);
  assign ax     = CW1'(avoid_x);
  assign ay     = CW1'(avoid_y);
  assign dx     = (cx >= ax) ? (cx - ax) : (ax - cx);
  assign dy     = (cy >= ay) ? (cy - ay) : (ay - cy);
  assign accept = (cx <= CW1'(XMAX)) && (cy <= CW1'(YMAX)) &&
                  !(avoid_en && (dx < CW1'(SQ_SIZE)) && (dy < CW1'(SQ_SIZE)));

  // LFSR register, advances every clock
  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr <= SEED_EFF;
    else       lfsr <= lfsr_d;
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state;
    tries_d    = tries;
    cand_x_d   = cand_x;
    cand_y_d   = cand_y;
    x_loc_d    = x_loc;
    y_loc_d    = y_loc;
    valid_d    = 1'b0;
    busy_d     = busy;
    fallback_d = fallback;
    case (state)
      IDLE: begin
        if (start) begin
          state_d = DRAW;
          busy_d  = 1'b1;
          tries_d = '0;
        end
      end
      DRAW: begin
        cand_x_d = COORD_W'(lfsr[XB-1:0]);
        cand_y_d = COORD_W'(lfsr[LFSR_W-1 -: YB]);
        state_d  = CHECK;
      end
      CHECK: begin
        if (accept) begin
          x_loc_d    = cand_x;
          y_loc_d    = cand_y;
          valid_d    = 1'b1;
          fallback_d = 1'b0;
          busy_d     = 1'b0;
          state_d    = IDLE;
        end else if (tries == TW'(MAX_TRIES - 1)) begin
          x_loc_d    = COORD_W'(FALLBACK_X);
          y_loc_d    = COORD_W'(FALLBACK_Y);
          valid_d    = 1'b1;
          fallback_d = 1'b1;
          busy_d     = 1'b0;
          state_d    = IDLE;
        end else begin
          tries_d = tries + TW'(1);
          state_d = DRAW;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      tries    <= '0;
      cand_x   <= '0;
      cand_y   <= '0;
      x_loc    <= '0;
      y_loc    <= '0;
      valid    <= 1'b0;
      busy     <= 1'b0;
      fallback <= 1'b0;
    end else begin
      state    <= state_d;
      tries    <= tries_d;
      cand_x   <= cand_x_d;
      cand_y   <= cand_y_d;
      x_loc    <= x_loc_d;
      y_loc    <= y_loc_d;
      valid    <= valid_d;
      busy     <= busy_d;
      fallback <= fallback_d;
    end
  end

endmodule
